// File: rtl/mc_path_ctrl_pkg.sv
// ============================================================================
// Module      : lib_cpu (package)
// Description : Shared types for the multicycle path controller: FSM state
//               encoding, opcode values and datapath mux encodings.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lib_cpu;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        ILLEGAL = 4'd12
    } MC_STATE;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDI  = 6'b001000,
        LW    = 6'b100011,
        SW    = 6'b101011
    } OPECODE;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_path_ctrl_if.sv
// ============================================================================
// Module      : mc_path_ctrl_if
// Description : Controller <-> datapath/memory signal bundle. The master
//               modport is the controller side.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mc_path_ctrl_if;

    lib_cpu::OPECODE op;
    logic            mem_ready;
    logic            mem_req;
    logic            iord;
    logic            mem_write;
    logic            ir_write;
    logic            pc_write;
    logic            branch;
    logic            branch_ne;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      pc_src;
    logic [1:0]      alu_op;
    logic            illegal;

    modport master (
        input  op, mem_ready,
        output mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal
    );

endinterface

`default_nettype wire

// File: rtl/mc_path_ctrl_next_state.sv
// ============================================================================
// Module      : mc_next_state
// Description : Next-state logic of the multicycle controller FSM.
//               Build option MC_PATH_CTRL_BNE_EN routes BNE to BRANCH.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_next_state
    import lib_cpu::*;
(
    input  MC_STATE i_state,
    input  OPECODE  i_op,
    input  logic    i_mem_ready,
    output MC_STATE o_next
);

    always_comb begin
        o_next = FETCH;
        case (i_state)
            FETCH:   o_next = i_mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (i_op)
                    LW, SW:  o_next = MEMADR;
                    RTYPE:   o_next = EXECUTE;
                    BEQ:     o_next = BRANCH;
`ifdef MC_PATH_CTRL_BNE_EN
                    BNE:     o_next = BRANCH;
`endif
                    ADDI:    o_next = ADDIEX;
                    J:       o_next = JUMP;
                    default: o_next = ILLEGAL;
                endcase
            end
            // Only LW/SW can reach MEMADR, so the latched opcode picks the side
            MEMADR:  o_next = (i_op == SW) ? MEMWR : MEMRD;
            MEMRD:   o_next = i_mem_ready ? MEMWB : MEMRD;
            MEMWB:   o_next = FETCH;
            MEMWR:   o_next = i_mem_ready ? FETCH : MEMWR;
            EXECUTE: o_next = ALUWB;
            ALUWB:   o_next = FETCH;
            BRANCH:  o_next = FETCH;
            ADDIEX:  o_next = ADDIWB;
            ADDIWB:  o_next = FETCH;
            JUMP:    o_next = FETCH;
            ILLEGAL: o_next = ILLEGAL;
            default: o_next = FETCH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_path_ctrl.sv
// ============================================================================
// Module      : mc_path_ctrl
// Description : Moore-style multicycle CPU path controller with opcode latch.
//               Build option MC_PATH_CTRL_BNE_EN enables BNE / branch_ne.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_path_ctrl
    import lib_cpu::*;
(
    input  logic          clk,
    input  logic          reset,
    mc_path_ctrl_if.master bus
);

    MC_STATE state_q, state_d, w_next_state;
    OPECODE  opcode_q, opcode_d, w_ns_op;

    // DECODE looks at the live opcode; later states only see the latched copy
    assign w_ns_op = (state_q == DECODE) ? bus.op : opcode_q;

    mc_next_state u_next_state (
        .i_state     (state_q),
        .i_op        (w_ns_op),
        .i_mem_ready (bus.mem_ready),
        .o_next      (w_next_state)
    );

    always_comb begin
        state_d  = w_next_state;
        opcode_d = (state_q == DECODE) ? bus.op : opcode_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            opcode_q <= RTYPE;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    logic       w_mem_req, w_iord, w_mem_write, w_ir_write, w_pc_write;
    logic       w_branch, w_branch_ne, w_reg_dst, w_mem_to_reg, w_reg_write;
    logic       w_alu_src_a, w_illegal;
    logic [1:0] w_alu_src_b, w_pc_src, w_alu_op;

    always_comb begin
        w_mem_req    = 1'b0;
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_illegal    = 1'b0;
        w_alu_src_b  = SRCB_REG;
        w_pc_src     = PCSRC_ALU;
        w_alu_op     = ALUOP_ADD;
        // Reset blanks every strobe immediately, before the state flop clears
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    w_mem_req   = 1'b1;
                    w_alu_src_b = SRCB_FOUR;
                    w_ir_write  = bus.mem_ready;
                    w_pc_write  = bus.mem_ready;
                end
                DECODE:  w_alu_src_b = SRCB_IMM_SH2;
                MEMADR: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = SRCB_IMM;
                end
                MEMRD: begin
                    w_mem_req = 1'b1;
                    w_iord    = 1'b1;
                end
                MEMWB: begin
                    w_mem_to_reg = 1'b1;
                    w_reg_write  = 1'b1;
                end
                MEMWR: begin
                    w_mem_req   = 1'b1;
                    w_iord      = 1'b1;
                    w_mem_write = 1'b1;
                end
                EXECUTE: begin
                    w_alu_src_a = 1'b1;
                    w_alu_op    = ALUOP_FUNCT;
                end
                ALUWB: begin
                    w_reg_dst   = 1'b1;
                    w_reg_write = 1'b1;
                end
                BRANCH: begin
                    w_alu_src_a = 1'b1;
                    w_alu_op    = ALUOP_SUB;
                    w_pc_src    = PCSRC_ALUOUT;
                    w_branch    = 1'b1;
`ifdef MC_PATH_CTRL_BNE_EN
                    w_branch_ne = (opcode_q == BNE);
`endif
                end
                ADDIEX: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = SRCB_IMM;
                end
                ADDIWB:  w_reg_write = 1'b1;
                JUMP: begin
                    w_pc_src   = PCSRC_JUMP;
                    w_pc_write = 1'b1;
                end
                ILLEGAL: w_illegal = 1'b1;
                default: w_illegal = 1'b0;
            endcase
        end
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.iord       = w_iord;
    assign bus.mem_write  = w_mem_write;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.branch     = w_branch;
    assign bus.branch_ne  = w_branch_ne;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.reg_write  = w_reg_write;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_op     = w_alu_op;
    assign bus.illegal    = w_illegal;

endmodule

`default_nettype wire

// File: doc/mc_path_ctrl.md
MC_PATH_CTRL -- requirements
Module: mc_path_ctrl

Interface
REQ-001 SHALL have clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-002 SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have op, input, OPECODE (6 bits): opcode field of the instruction register, sampled in DECODE.
REQ-004 SHALL have mem_ready, input, 1 bit: memory completion for the current mem_req cycle.
REQ-005 SHALL have outputs mem_req, iord, mem_write, ir_write, pc_write, branch, reg_dst, mem_to_reg, reg_write, alu_src_a, each 1 bit: datapath strobes and mux selects.
REQ-006 SHALL have alu_src_b[1:0], pc_src[1:0] and alu_op[1:0] outputs: src_b 00=reg B, 01=4, 10=sign-extended immediate, 11=immediate<<2; pc_src 00=ALU result, 01=ALU register, 10=jump target.
REQ-007 SHALL have illegal, output, 1 bit: high while trapped on an undecodable opcode.

Function
REQ-008 SHALL implement a Moore FSM; every output is a function of the current state plus mem_ready only.
REQ-009 SHALL drive every output not listed for a state to 0 (never x).
REQ-010 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_write=mem_ready; go to DECODE when mem_ready, else stay.
REQ-011 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state from op: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, other->ILLEGAL.
REQ-012 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD if the opcode latched in DECODE is LW, MEMWR if SW.
REQ-013 MEMRD: mem_req=1, iord=1; stay until mem_ready, then MEMWB.
REQ-014 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
REQ-015 MEMWR: mem_req=1, iord=1, mem_write=1; stay until mem_ready, then FETCH.
REQ-016 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB. ALUWB: reg_dst=1, reg_write=1; next FETCH.
REQ-017 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1; next FETCH.
REQ-018 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDIWB. ADDIWB: reg_dst=0, reg_write=1; next FETCH.
REQ-019 JUMP: pc_src=10, pc_write=1; next FETCH.
REQ-020 ILLEGAL: illegal=1, all strobes 0; stays in ILLEGAL until reset.
REQ-021 Latency without memory wait: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3 cycles.
REQ-022 Each mem_ready wait cycle SHALL add exactly one cycle; mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-023 The opcode SHALL be latched into an internal register in DECODE; op changes after DECODE SHALL NOT affect the sequence.

Reset
REQ-024 With reset high at a clock edge, state SHALL become FETCH and the opcode register RTYPE, from any state including mid-wait and ILLEGAL.
REQ-025 With reset high, all outputs SHALL be forced to 0 combinationally (mem_req=0, no pc_write/ir_write).

Configuration
REQ-026 With MC_PATH_CTRL_BNE_EN defined, opcode BNE (000101) SHALL go DECODE->BRANCH and additionally drive output branch_ne=1 in BRANCH.
REQ-027 Without MC_PATH_CTRL_BNE_EN, branch_ne SHALL still exist tied to 0, and BNE SHALL decode to ILLEGAL.

Structure
REQ-028 The state enum MC_STATE (4 bits, explicit encodings) and BNE in OPECODE SHALL live in lib_cpu; the alu_src_b/pc_src encodings SHALL be lib_cpu localparams.
REQ-029 A next-state sub-module mc_next_state (state, op, mem_ready -> next) SHALL be used; output decode stays in mc_path_ctrl.

Verification
REQ-030 Reset, then op=LW, mem_ready=1 constantly -> FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-031 op=SW, mem_ready low for 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles, then FETCH; cycle count 7.
REQ-032 op=BEQ then J back-to-back -> branch=1 with pc_src=01 in cycle 3; pc_write=1 with pc_src=10 in cycle 6.
REQ-033 op=6'b111111 -> illegal=1 from cycle 3, held 10 cycles; reset pulse -> FETCH, illegal=0.
REQ-034 Reset asserted during MEMRD wait -> next cycle FETCH, mem_req=0 during the reset cycle.
REQ-035 op=BNE with and without MC_PATH_CTRL_BNE_EN -> BRANCH with branch_ne=1 / ILLEGAL respectively.
